// File: rtl/aes_shiftmix_addkey.sv
// aes_shiftmix_addkey: column-serial ShiftRows, MixColumns and AddRoundKey AES round back-end
module aes_shiftmix_addkey #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);
  typedef enum logic [1:0] {IDLE, PROC, DONE} st_t;
  st_t st, st_n;
  logic [127:0] s, k, res, res_n, so;
  logic [31:0] a, r;
  logic [1:0] col;
  logic [6:0] base;
  logic lr, acc;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < NCOL; c++)
      for (int q = 0; q < 4; q++)
        y[127-8*(4*c+q) -: 8] = x[127-8*(4*((c+q)%NCOL)+q) -: 8];
    return y;
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] x);
    logic [7:0] b [4];
    logic [31:0] y;
    y = '0;
    for (int q = 0; q < 4; q++) b[q] = x[31-8*q -: 8];
    for (int q = 0; q < 4; q++)
      y[31-8*q -: 8] = xt(b[q]) ^ xt(b[(q+1)%4]) ^ b[(q+1)%4] ^ b[(q+2)%4] ^ b[(q+3)%4];
    return y;
  endfunction
  assign in_ready = st == IDLE || (st == DONE && out_ready);
  assign out_valid = st == DONE;
  assign state_out = so;
  assign acc = in_valid && in_ready;
  // current column result and next-state selection
  always_comb begin
    base = {~col, 5'b0};
    a = s[base +: 32];
    r = (lr ? a : mix(a)) ^ k[base +: 32];
    res_n = res;
    res_n[base +: 32] = r;
    st_n = st == IDLE ? (acc ? PROC : IDLE) :
           st == PROC ? (col == 2'd3 ? DONE : PROC) :
           (acc ? PROC : (out_ready ? IDLE : DONE));
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  // block capture, column accumulation and output latch on entering DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      k <= '0;
      lr <= 1'b0;
      col <= '0;
      res <= '0;
      so <= '0;
    end else if (acc) begin
      s <= shift_rows(state_in);
      k <= key_in;
      lr <= last_round;
      col <= '0;
    end else if (st == PROC) begin
      res <= res_n;
      col <= col + 2'd1;
      if (col == 2'd3) so <= res_n;
    end
endmodule
